fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer that sits directly upstream of the 16-bit program counter. It reads the instruction at the current PC from instruction memory and hands it to the execute stage over a valid/ready handshake. It then decodes the branch class and drives the PC's one-hot inc/add/sub controls and 16-bit offset for exactly one cycle per instruction. It is the only driver of the PC control inputs.

Parameters:
ADDR_W, 16, PC/address width; must equal PC width
INSN_W, 16, instruction width; opcode = insn[INSN_W-1:INSN_W-4], imm12 = insn[11:0]

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  leave IDLE and begin fetching
pc  input  ADDR_W  current PC value from the PC block
zero  input  1  zero flag from execute; sampled in UPDATE only
mem_req  output  1  instruction-memory read request
mem_addr  output  ADDR_W  read address; equals pc while mem_req=1, else 0
mem_ack  input  1  memory returns mem_rdata in this cycle
mem_rdata  input  INSN_W  instruction word
insn  output  INSN_W  latched instruction register
insn_valid  output  1  insn offered to execute
insn_ready  input  1  execute accepts insn
inc  output  1  PC += 1 (one-cycle pulse)
add  output  1  PC += offset (one-cycle pulse)
sub  output  1  PC -= offset (one-cycle pulse)
offset  output  ADDR_W  {4'b0, imm12}; 0 when add=sub=0
busy  output  1  state != IDLE

Behaviour:
- Reset (reset=0, async): state=IDLE; insn=0; mem_req, insn_valid, inc, add, sub, busy all 0; mem_addr=0; offset=0. Outputs are registered or decoded from state only, so all are 0 immediately.
- FSM states: IDLE, FETCH, ISSUE, UPDATE.
- IDLE: all outputs 0. start=1 moves to FETCH next edge. mem_ack and insn_ready are ignored.
- FETCH: mem_req=1, mem_addr=pc. On an edge with mem_ack=1, insn<=mem_rdata and state goes to ISSUE. Otherwise stay with mem_req held high and address stable.
- ISSUE: insn_valid=1, insn held stable. On an edge with insn_ready=1, state goes to UPDATE. insn_valid must not drop before acceptance.
- UPDATE: one cycle. Exactly one of inc/add/sub is high, selected by opcode:
  - 4'hF JMPF: add=1, offset={4'b0,imm12}
  - 4'hE JMPB: sub=1, offset={4'b0,imm12}
  - 4'hD BZ: if zero=1 then add=1 with offset={4'b0,imm12}, else inc=1
  - 4'h0 HALT: inc=1; next state IDLE
  - all others: inc=1
  - Next state is FETCH, except HALT, which goes to IDLE.
- Branch offsets are relative to the PC of the branch instruction itself, because the PC has not advanced yet. imm12=0 on JMPF gives a self-loop; this is legal.
- The PC updates on the edge that ends UPDATE, so the next FETCH presents the new pc.
- Minimum throughput: 3 cycles per instruction (ack in the first FETCH cycle, ready in the first ISSUE cycle).
- start is ignored outside IDLE.
- Arithmetic wraps modulo 2^ADDR_W inside the PC; fetch_ctrl performs no range checks.
- Reset asserted mid-operation aborts immediately. Any partial PC pulse is suppressed. No PC update occurs for an instruction that was not accepted.
- Invariant, checked by assertion: inc+add+sub <= 1 every cycle, and all three are 0 outside UPDATE.

Test Plan:
- Reset low 2 cycles, then high, start=0 -> all outputs 0, busy=0 and remain 0 for 10 cycles, even with mem_ack=1.
- start pulse, memory returns 16'h1234 at PCs 0,1,2 with ack and ready the same cycle -> mem_addr sequence 0,1,2, each 3 cycles apart; inc pulses once per instruction; pc=3 after the third UPDATE.
- At pc=0x0004, rdata=16'hF005 -> UPDATE has add=1, offset=0x0005, next mem_addr=0x0009. At pc=0x0009, rdata=16'hE003 -> sub=1, offset=0x0003, next mem_addr=0x0006.
- BZ 16'hD010 at pc=0x0020: zero=1 -> add, next addr 0x0030. Repeat with zero=0 -> inc, next addr 0x0021.
- mem_ack delayed 3 cycles and insn_ready delayed 2 cycles -> mem_req and mem_addr stable for 4 cycles; insn_valid and insn stable for 3 cycles; exactly one inc follows.
- Reset asserted during ISSUE -> insn_valid and mem_req drop immediately, no inc/add/sub, pc unchanged. Separately, rdata=16'h0000 -> inc, then IDLE with busy=0; a later start resumes fetch at the old pc+1.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl
// ----------
// Instruction-fetch sequencer sitting directly in front of the program
// counter. For each instruction it reads memory at the current pc, offers
// the word to the execute stage, then pulses exactly one of the PC controls
// (inc / add / sub) for a single cycle based on the branch class.
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset (0 = in reset)
//   start       leave IDLE and begin fetching (ignored elsewhere)
//   pc          current PC value from the PC block
//   zero        zero flag from execute, only looked at during UPDATE
//   mem_req     instruction-memory read request
//   mem_addr    read address, pc while mem_req=1, otherwise 0
//   mem_ack     memory delivers mem_rdata this cycle
//   mem_rdata   instruction word from memory
//   insn        latched instruction register
//   insn_valid  insn offered to execute
//   insn_ready  execute accepts insn
//   inc/add/sub one-cycle PC control pulses, at most one high
//   offset      {4'b0, imm12} while add or sub is high, else 0
//   busy        high whenever the sequencer is not IDLE

module fetch_ctrl #(
    parameter int ADDR_W = 16,
    parameter int INSN_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] pc,
    input  logic              zero,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [INSN_W-1:0] mem_rdata,
    output logic [INSN_W-1:0] insn,
    output logic              insn_valid,
    input  logic              insn_ready,
    output logic              inc,
    output logic              add,
    output logic              sub,
    output logic [ADDR_W-1:0] offset,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        ISSUE  = 2'd2,
        UPDATE = 2'd3
    } state_t;

    localparam logic [3:0] OP_HALT = 4'h0;
    localparam logic [3:0] OP_BZ   = 4'hD;
    localparam logic [3:0] OP_JMPB = 4'hE;
    localparam logic [3:0] OP_JMPF = 4'hF;

    state_t            state;
    logic [3:0]        opcode;
    logic [ADDR_W-1:0] imm_ext;

    assign opcode  = insn[INSN_W-1 -: 4];
    assign imm_ext = ADDR_W'(insn[11:0]);

    // Sequencer. mem_req, insn_valid and busy are registered alongside the
    // state so they change only on the edge that changes the state, and all
    // of them clear the instant reset is asserted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            insn       <= '0;
            mem_req    <= 1'b0;
            insn_valid <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FETCH;
                        mem_req <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        insn       <= mem_rdata;
                        state      <= ISSUE;
                        mem_req    <= 1'b0;
                        insn_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (insn_ready) begin
                        state      <= UPDATE;
                        insn_valid <= 1'b0;
                    end
                end
                UPDATE: begin
                    if (opcode == OP_HALT) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state   <= FETCH;
                        mem_req <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    mem_req    <= 1'b0;
                    insn_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

    // The address follows pc live so a PC that changed on the edge ending
    // UPDATE is presented straight away in the next FETCH.
    assign mem_addr = mem_req ? pc : '0;

    // PC control decode. Combinational on purpose: zero is only meaningful
    // during UPDATE itself, so it cannot be captured a cycle early. Outside
    // UPDATE (including reset, which forces IDLE) everything stays at 0.
    always_comb begin
        inc    = 1'b0;
        add    = 1'b0;
        sub    = 1'b0;
        offset = '0;
        if (state == UPDATE) begin
            case (opcode)
                OP_JMPF: begin
                    add    = 1'b1;
                    offset = imm_ext;
                end
                OP_JMPB: begin
                    sub    = 1'b1;
                    offset = imm_ext;
                end
                OP_BZ: begin
                    if (zero) begin
                        add    = 1'b1;
                        offset = imm_ext;
                    end else begin
                        inc = 1'b1;
                    end
                end
                default: inc = 1'b1;
            endcase
        end
    end

    // The PC must never see two controls at once, nor any control outside
    // the single UPDATE cycle.
    assert property (@(posedge clk) disable iff (!reset)
        ($countones({inc, add, sub}) <= 1) &&
        ((state == UPDATE) || !(inc || add || sub)));

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl
// -------------
// Bench for fetch_ctrl. Contains a small PC block driven by the DUT's
// inc/add/sub/offset, a transaction-level reference that predicts handshake
// phase and the PC each instruction must produce, a per-cycle compare
// process, and directed scenarios with literal expectations.

module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [15:0] pc = '0;
    logic        zero = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic [15:0] insn;
    logic        insn_valid;
    logic        insn_ready = 1'b0;
    logic        inc;
    logic        add;
    logic        sub;
    logic [15:0] offset;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int cycle_cnt = 0;
    int inc_count = 0;

    logic        pc_load = 1'b0;
    logic [15:0] pc_load_val = '0;

    // reference: 0 waiting for start, 1 waiting for memory,
    // 2 offering to execute, 3 PC-update cycle
    int          m_phase = 0;
    logic [15:0] m_insn = '0;

    fetch_ctrl #(.ADDR_W(16), .INSN_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pc         (pc),
        .zero       (zero),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .insn       (insn),
        .insn_valid (insn_valid),
        .insn_ready (insn_ready),
        .inc        (inc),
        .add        (add),
        .sub        (sub),
        .offset     (offset),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Comparison helper shared by the compare process and the scenarios.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at t=%0t",
                     name, actual, expected, $time);
        end
    endtask

    // Where the PC must end up after an instruction, from the branch rules.
    function automatic logic [15:0] model_next_pc(input logic [15:0] p,
                                                  input logic [15:0] w,
                                                  input logic z);
        logic [15:0] imm;
        imm = {4'b0, w[11:0]};
        case (w[15:12])
            4'hF:    return p + imm;
            4'hE:    return p - imm;
            4'hD:    return z ? p + imm : p + 16'd1;
            default: return p + 16'd1;
        endcase
    endfunction

    function automatic logic [15:0] model_offset(input logic [15:0] w,
                                                 input logic z);
        if (w[15:12] == 4'hF || w[15:12] == 4'hE ||
            (w[15:12] == 4'hD && z))
            return {4'b0, w[11:0]};
        return 16'h0000;
    endfunction

    // PC block under DUT control, plus a bench-side load port.
    always @(posedge clk) begin
        cycle_cnt <= cycle_cnt + 1;
        if (pc_load)
            pc <= pc_load_val;
        else if (inc)
            pc <= pc + 16'd1;
        else if (add)
            pc <= pc + offset;
        else if (sub)
            pc <= pc - offset;
    end

    // Reference handshake progress driven by the inputs the DUT sees.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase <= 0;
            m_insn  <= '0;
        end else begin
            case (m_phase)
                0: if (start) m_phase <= 1;
                1: if (mem_ack) begin
                       m_insn  <= mem_rdata;
                       m_phase <= 2;
                   end
                2: if (insn_ready) m_phase <= 3;
                default: m_phase <= (m_insn[15:12] == 4'h0) ? 0 : 1;
            endcase
        end
    end

    // Per-cycle compare against the reference, away from the active edge.
    always @(negedge clk) begin
        logic [15:0] dut_next;
        int          hot;
        if (reset) begin
            hot = int'(inc) + int'(add) + int'(sub);
            if (inc) inc_count++;
            checkOutput("busy", busy, m_phase != 0);
            checkOutput("mem_req", mem_req, m_phase == 1);
            checkOutput("mem_addr", mem_addr, (m_phase == 1) ? pc : 16'h0);
            checkOutput("insn_valid", insn_valid, m_phase == 2);
            checkOutput("insn", insn, m_insn);
            if (m_phase == 3) begin
                dut_next = inc ? pc + 16'd1 : add ? pc + offset :
                           sub ? pc - offset : pc;
                checkOutput("pulse_onehot", hot, 1);
                checkOutput("next_pc", dut_next, model_next_pc(pc, m_insn, zero));
                checkOutput("offset", offset, model_offset(m_insn, zero));
            end else begin
                checkOutput("pulse_idle", hot, 0);
                checkOutput("offset_idle", offset, 0);
            end
        end
    end

    task automatic set_pc(input logic [15:0] v);
        pc_load_val = v;
        pc_load = 1'b1;
        @(posedge clk); #1;
        pc_load = 1'b0;
    endtask

    task automatic start_fetch();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // One full instruction: optional memory and execute stalls, then the
    // UPDATE cycle whose pulses are returned for literal checks.
    task automatic applyStimulus(input logic [15:0] rdata, input int ack_wait,
                                 input int ready_wait, input logic z,
                                 output logic [15:0] addr, output int fetch_cycle,
                                 output logic u_inc, output logic u_add,
                                 output logic u_sub, output logic [15:0] u_off);
        int guard;
        guard = 0;
        addr = '0; fetch_cycle = 0;
        u_inc = 0; u_add = 0; u_sub = 0; u_off = '0;
        while (!mem_req && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!mem_req) begin
            checkOutput("fetch_timeout", 0, 1);
            return;
        end
        addr = mem_addr;
        fetch_cycle = cycle_cnt;
        repeat (ack_wait) begin
            @(posedge clk); #1;
            checkOutput("req_hold", mem_req, 1);
            checkOutput("addr_hold", mem_addr, addr);
        end
        mem_ack = 1'b1;
        mem_rdata = rdata;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        mem_rdata = 16'hbeef;
        checkOutput("valid_on", insn_valid, 1);
        checkOutput("insn_latched", insn, rdata);
        repeat (ready_wait) begin
            @(posedge clk); #1;
            checkOutput("valid_hold", insn_valid, 1);
            checkOutput("insn_hold", insn, rdata);
        end
        insn_ready = 1'b1;
        zero = z;
        @(posedge clk); #1;
        insn_ready = 1'b0;
        u_inc = inc; u_add = add; u_sub = sub; u_off = offset;
        @(posedge clk); #1;
        zero = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] a;
        int          c0, c1, c2, inc_before;
        logic        ui, ua, us;
        logic [15:0] uo, saved_pc;

        // reset held, then released with start low and mem_ack high
        mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            checkOutput("idle_busy", busy, 0);
            checkOutput("idle_req", mem_req, 0);
        end
        mem_ack = 1'b0;

        // three plain instructions from pc 0 at full rate
        start_fetch();
        inc_before = inc_count;
        applyStimulus(16'h1234, 0, 0, 1'b0, a, c0, ui, ua, us, uo);
        checkOutput("seq_addr0", a, 16'h0000);
        applyStimulus(16'h1234, 0, 0, 1'b0, a, c1, ui, ua, us, uo);
        checkOutput("seq_addr1", a, 16'h0001);
        applyStimulus(16'h1234, 0, 0, 1'b0, a, c2, ui, ua, us, uo);
        checkOutput("seq_addr2", a, 16'h0002);
        checkOutput("seq_gap01", c1 - c0, 3);
        checkOutput("seq_gap12", c2 - c1, 3);
        checkOutput("seq_incs", inc_count - inc_before, 3);
        checkOutput("seq_pc", pc, 16'h0003);

        // forward then backward jump
        set_pc(16'h0004);
        applyStimulus(16'hF005, 0, 0, 1'b0, a, c0, ui, ua, us, uo);
        checkOutput("jmpf_addr", a, 16'h0004);
        checkOutput("jmpf_add", ua, 1);
        checkOutput("jmpf_off", uo, 16'h0005);
        checkOutput("jmpf_next", mem_addr, 16'h0009);
        applyStimulus(16'hE003, 0, 0, 1'b0, a, c0, ui, ua, us, uo);
        checkOutput("jmpb_addr", a, 16'h0009);
        checkOutput("jmpb_sub", us, 1);
        checkOutput("jmpb_off", uo, 16'h0003);
        checkOutput("jmpb_next", mem_addr, 16'h0006);

        // conditional branch taken and not taken
        set_pc(16'h0020);
        applyStimulus(16'hD010, 0, 0, 1'b1, a, c0, ui, ua, us, uo);
        checkOutput("bz_taken_add", ua, 1);
        checkOutput("bz_taken_next", mem_addr, 16'h0030);
        set_pc(16'h0020);
        applyStimulus(16'hD010, 0, 0, 1'b0, a, c0, ui, ua, us, uo);
        checkOutput("bz_not_inc", ui, 1);
        checkOutput("bz_not_next", mem_addr, 16'h0021);

        // stalled memory and execute
        inc_before = inc_count;
        applyStimulus(16'h1234, 3, 2, 1'b0, a, c0, ui, ua, us, uo);
        checkOutput("stall_incs", inc_count - inc_before, 1);
        checkOutput("stall_pc", pc, 16'h0022);

        // reset while the instruction is being offered
        mem_ack = 1'b1;
        mem_rdata = 16'hF001;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        checkOutput("abort_valid_before", insn_valid, 1);
        saved_pc = pc;
        #3 reset = 1'b0;
        #1;
        checkOutput("abort_valid", insn_valid, 0);
        checkOutput("abort_req", mem_req, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_pulses", {inc, add, sub}, 0);
        checkOutput("abort_insn", insn, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("abort_pc", pc, saved_pc);
        reset = 1'b1;

        // HALT returns to IDLE, then a new start resumes at pc+1
        start_fetch();
        applyStimulus(16'h0000, 0, 0, 1'b0, a, c0, ui, ua, us, uo);
        checkOutput("halt_addr", a, 16'h0022);
        checkOutput("halt_inc", ui, 1);
        checkOutput("halt_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("halt_stay_idle", mem_req, 0);
        start_fetch();
        checkOutput("resume_req", mem_req, 1);
        checkOutput("resume_addr", mem_addr, 16'h0023);
        @(posedge clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
